inst_mem_loader: RTL and testbench

Instruction memory with a byte-stream program loader, sitting directly upstream of the single-cycle MIPS core's instruction port. While a program is loaded it holds the core in reset. It assembles incoming bytes into 32-bit big-endian words and writes them sequentially from word 0. It then releases the core and serves `inst` combinationally from `inst_adr`.

---
 rtl/inst_mem_loader_if.sv | 28 ++
 rtl/inst_mem_loader.sv | 120 ++++++++++++
 tb/tb_inst_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Program-loader / instruction-fetch bundle between the byte source, the
// instruction memory and the MIPS core's instruction port.
interface inst_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              load_end;
    logic [31:0]       inst_adr;
    logic [31:0]       inst;
    logic              core_rst;
    logic              loading;
    logic [ADDR_W:0]   word_count;
    logic              overflow;

    // Memory side: receives the byte stream and the fetch address.
    modport slave (
        input  load_start, rx_valid, rx_data, load_end, inst_adr,
        output inst, core_rst, loading, word_count, overflow
    );

    // Driver side: the loader host and the core's fetch port.
    modport master (
        output load_start, rx_valid, rx_data, load_end, inst_adr,
        input  inst, core_rst, loading, word_count, overflow
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-stream program loader. Holds the core in
// reset while a program streams in, packs bytes big-endian into words written
// from word 0 upward, then releases the core and serves instructions
// combinationally from its byte address.
module inst_mem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    inst_mem_loader_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_WORD   = (ADDR_W+1)'(1);

    logic [1:0]        state;
    logic [1:0]        byte_cnt;
    logic [1:0]        cnt_next;
    logic [31:0]       asm_word;
    logic [31:0]       asm_next;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic [31:0]       mem [DEPTH];

    logic              in_load;
    logic              restart;
    logic              write_req;
    logic              full;
    logic              do_write;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_idx;
    logic              adr_hi_zero;
    logic              unused_adr_bits;

    assign in_load  = (state == ST_LOAD);
    assign restart  = bus.load_start;
    assign full     = (word_count == FULL_COUNT);
    // The word counter never wraps, so its low bits double as the write pointer.
    assign wr_ptr   = word_count[ADDR_W-1:0];

    // Merge an accepted byte into its lane; end-of-load then sees the updated count.
    always_comb begin
        asm_next = asm_word;
        cnt_next = byte_cnt;
        if (bus.rx_valid) begin
            case (byte_cnt)
                2'd0:    asm_next[31:24] = bus.rx_data;
                2'd1:    asm_next[23:16] = bus.rx_data;
                2'd2:    asm_next[15:8]  = bus.rx_data;
                default: asm_next[7:0]   = bus.rx_data;
            endcase
            cnt_next = byte_cnt + 2'd1;
        end
    end

    // A completing 4th byte and a trailing partial word are mutually exclusive,
    // so a word finished together with load_end is written exactly once.
    assign write_req = in_load && !restart &&
                       ((bus.rx_valid && (byte_cnt == 2'd3)) ||
                        (bus.load_end && (cnt_next != 2'd0)));
    assign do_write  = write_req && !full;

    // Load/run state machine and load bookkeeping; load_start always wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (restart) begin
            state      <= ST_LOAD;
            byte_cnt   <= 2'd0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (in_load) begin
            byte_cnt <= cnt_next;
            if (do_write)
                word_count <= word_count + ONE_WORD;
            if (write_req && full)
                overflow <= 1'b1;
            if (bus.load_end)
                state <= ST_RUN;
        end
    end

    // Assembly register: cleared at load entry and after every completed word
    // so a trailing partial word carries zeros in its unfilled low lanes.
    always_ff @(posedge clk) begin
        if (restart)
            asm_word <= 32'd0;
        else if (in_load)
            asm_word <= (cnt_next == 2'd0) ? 32'd0 : asm_next;
    end

    // Program storage; contents are not reset, visibility is bounded by word_count.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= asm_next;
    end

    assign rd_idx          = bus.inst_adr[ADDR_W+1:2];
    assign adr_hi_zero     = (bus.inst_adr[31:ADDR_W+2] == '0);
    assign unused_adr_bits = ^bus.inst_adr[1:0];

    // Zero-latency fetch; anything not loaded or outside memory reads as a nop.
    always_comb begin
        bus.inst = 32'd0;
        if ((state == ST_RUN) && adr_hi_zero && ({1'b0, rd_idx} < word_count))
            bus.inst = mem[rd_idx];
    end

    assign bus.core_rst   = (state != ST_RUN);
    assign bus.loading    = in_load;
    assign bus.word_count = word_count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed and randomized program
// loads compared against a byte-queue reference model.
module tb_inst_mem_loader;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bq_t  q;
    bq_t  qs;
    bit   run_m = 1'b0;

    inst_mem_loader_if #(.ADDR_W(8)) a ();
    inst_mem_loader_if #(.ADDR_W(2)) b ();

    inst_mem_loader #(.DEPTH(256), .ADDR_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(a.slave)
    );
    inst_mem_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .bus(b.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_done(bq_t bq, int depth);
        int w = bq.size() / 4;
        return (w > depth) ? depth : w;
    endfunction

    function automatic int m_final(bq_t bq, int depth);
        int w = (bq.size() + 3) / 4;
        return (w > depth) ? depth : w;
    endfunction

    function automatic logic [31:0] m_ovf(bq_t bq, int depth);
        return ((bq.size() + 3) / 4 > depth) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] m_word(bq_t bq, int i);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++)
            if (4 * i + k < bq.size()) w[31 - 8 * k -: 8] = bq[4 * i + k];
        return w;
    endfunction

    function automatic logic [31:0] exp_inst(logic [31:0] adr);
        int idx;
        if (!run_m || adr[31:10] != 22'd0) return 32'd0;
        idx = int'(adr[9:2]);
        return (idx < m_final(q, 256)) ? m_word(q, idx) : 32'd0;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a.load_start = 0; a.load_end = 0; a.rx_valid = 0; a.rx_data = 8'h00;
        b.load_start = 0; b.load_end = 0; b.rx_valid = 0; b.rx_data = 8'h00;
    endtask

    task automatic start_load();
        a.load_start = 1'b1;
        tick();
        a.load_start = 1'b0;
        q.delete();
        run_m = 1'b0;
        check("start_loading", 32'(a.loading), 32'd1);
        check("start_core_rst", 32'(a.core_rst), 32'd1);
        check("start_wc", 32'(a.word_count), 32'd0);
        check("start_ovf", 32'(a.overflow), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d);
        repeat ($urandom_range(0, 2)) tick();
        a.rx_valid = 1'b1;
        a.rx_data  = d;
        tick();
        a.rx_valid = 1'b0;
        q.push_back(d);
        check("load_wc", 32'(a.word_count), 32'(m_done(q, 256)));
        check("load_core_rst", 32'(a.core_rst), 32'd1);
    endtask

    task automatic end_load(input logic [7:0] d, input bit with_byte);
        a.load_end = 1'b1;
        if (with_byte) begin
            a.rx_valid = 1'b1;
            a.rx_data  = d;
            q.push_back(d);
        end
        tick();
        a.load_end = 1'b0;
        a.rx_valid = 1'b0;
        run_m = 1'b1;
        check("end_core_rst", 32'(a.core_rst), 32'd0);
        check("end_loading", 32'(a.loading), 32'd0);
        check("end_wc", 32'(a.word_count), 32'(m_final(q, 256)));
        check("end_ovf", 32'(a.overflow), m_ovf(q, 256));
    endtask

    task automatic check_read(input logic [31:0] adr);
        a.inst_adr = adr;
        @(negedge clk);
        check("inst_model", a.inst, exp_inst(adr));
    endtask

    task automatic read_expect(input logic [31:0] adr, input logic [31:0] exp);
        a.inst_adr = adr;
        @(negedge clk);
        check("inst_const", a.inst, exp);
        check("inst_model", a.inst, exp_inst(adr));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        idle_inputs();
        a.inst_adr = 32'd0;
        b.inst_adr = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_inst", a.inst, 32'd0);
        check("rst_core_rst", 32'(a.core_rst), 32'd1);
        check("rst_loading", 32'(a.loading), 32'd0);
        check("rst_wc", 32'(a.word_count), 32'd0);
        check("rst_ovf", 32'(a.overflow), 32'd0);
        rst = 1'b1;

        // Idle after reset, arbitrary fetch addresses.
        for (int i = 0; i < 10; i++) begin
            a.inst_adr = (i % 2 == 0) ? $urandom : 32'(4 * i);
            tick();
            check("idle_inst", a.inst, 32'd0);
            check("idle_core_rst", 32'(a.core_rst), 32'd1);
            check("idle_wc", 32'(a.word_count), 32'd0);
        end

        // load_end outside LOAD is ignored.
        a.load_end = 1'b1;
        tick();
        a.load_end = 1'b0;
        check("idle_end_core_rst", 32'(a.core_rst), 32'd1);
        check("idle_end_loading", 32'(a.loading), 32'd0);

        // Two complete words.
        start_load();
        foreach (q[i]) ; // q empty after start
        begin
            logic [7:0] p1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
            for (int i = 0; i < 8; i++) send_byte(p1[i]);
        end
        check("t1_pre_end_core_rst", 32'(a.core_rst), 32'd1);
        end_load(8'h00, 1'b0);
        check("t1_wc", 32'(a.word_count), 32'd2);
        read_expect(32'd0, 32'h2008_0005);
        read_expect(32'd4, 32'h2009_0007);
        read_expect(32'd8, 32'd0);
        read_expect(32'd5, 32'h2009_0007);

        // Partial trailing word padded with zeros.
        start_load();
        begin
            logic [7:0] p2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
            for (int i = 0; i < 6; i++) send_byte(p2[i]);
        end
        end_load(8'h00, 1'b0);
        check("t2_wc", 32'(a.word_count), 32'd2);
        read_expect(32'd0, 32'hAABB_CCDD);
        read_expect(32'd4, 32'h1122_0000);

        // Reload from RUN: stale word 1 must disappear.
        start_load();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        end_load(8'h00, 1'b0);
        read_expect(32'd4, 32'd0);
        check_read(32'd0);

        // 4th byte together with load_end: exactly one word.
        start_load();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        end_load(8'($urandom), 1'b1);
        check("t3_wc", 32'(a.word_count), 32'd1);
        read_expect(32'd4, 32'd0);
        check_read(32'd0);

        // Bytes while in RUN are ignored.
        a.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a.rx_data = 8'($urandom);
            tick();
        end
        a.rx_valid = 1'b0;
        check("run_rx_wc", 32'(a.word_count), 32'd1);
        check_read(32'd0);

        // load_start and load_end together mid-load: restart wins.
        start_load();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        a.load_start = 1'b1;
        a.load_end   = 1'b1;
        tick();
        idle_inputs();
        q.delete();
        check("both_loading", 32'(a.loading), 32'd1);
        check("both_wc", 32'(a.word_count), 32'd0);
        check("both_core_rst", 32'(a.core_rst), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        end_load(8'h00, 1'b0);
        check_read(32'd0);
        check_read(32'd4);

        // Randomized programs.
        for (int r = 0; r < 6; r++) begin
            int n;
            bit tail;
            start_load();
            n    = $urandom_range(0, 30);
            tail = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < (tail ? n - 1 : n); i++) send_byte(8'($urandom));
            end_load(8'($urandom), tail);
            for (int i = 0; i < m_final(q, 256) + 2; i++) check_read(32'(4 * i + $urandom_range(0, 3)));
            check_read($urandom | 32'h0000_0400);
        end

        // Small memory: overflow and no wrap.
        b.load_start = 1'b1;
        tick();
        b.load_start = 1'b0;
        qs.delete();
        for (int i = 0; i < 20; i++) begin
            b.rx_valid = 1'b1;
            b.rx_data  = 8'($urandom);
            qs.push_back(b.rx_data);
            tick();
        end
        b.rx_valid = 1'b0;
        b.load_end = 1'b1;
        tick();
        b.load_end = 1'b0;
        check("small_wc", 32'(b.word_count), 32'd4);
        check("small_ovf", 32'(b.overflow), 32'd1);
        check("small_core_rst", 32'(b.core_rst), 32'd0);
        for (int i = 0; i < 4; i++) begin
            b.inst_adr = 32'(4 * i);
            @(negedge clk);
            check("small_word", b.inst, m_word(qs, i));
        end
        b.inst_adr = 32'd16;
        @(negedge clk);
        check("small_out_of_range", b.inst, 32'd0);

        // Asynchronous reset in the middle of a load.
        start_load();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        #2 rst = 1'b0;
        #1;
        run_m = 1'b0;
        check("arst_core_rst", 32'(a.core_rst), 32'd1);
        check("arst_loading", 32'(a.loading), 32'd0);
        check("arst_wc", 32'(a.word_count), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_after_core_rst", 32'(a.core_rst), 32'd1);
        check("arst_after_loading", 32'(a.loading), 32'd0);
        a.inst_adr = 32'd0;
        @(negedge clk);
        check("arst_inst", a.inst, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
